// File: rtl/uart_frame_monitor.sv
// Oversampled UART receiver with configurable frame format (5..9 data bits,
// none/odd/even parity, 1 or 2 stop bits), false-start, parity, framing and
// line-break detection, and a first-word-fall-through output FIFO.
module uart_frame_monitor #(
  parameter int unsigned CLK_FREQ_MHZ = 27,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             uart_rx,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_BITS-1:0]             out_data,
  output logic                             out_parity_err,
  output logic                             out_frame_err,
  output logic                             out_break,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             overflow,
  input  logic                             clear_overflow
);

  localparam int unsigned DIV_RAW   = (CLK_FREQ_MHZ * 32'd1000000) / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned TICK_DIV  = (DIV_RAW > 0) ? DIV_RAW : 1;
  localparam int unsigned DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // The start edge reaches the FSM about three clocks after it hit the pin
  // (two synchronizer stages plus edge detect); pre-loading the divider by
  // that amount keeps the mid-bit samples centred on the real line timing.
  localparam int unsigned SYNC_COMP = (TICK_DIV > 3) ? 3 : TICK_DIV - 1;
  localparam int unsigned TICK_W    = $clog2(OVERSAMPLE);
  localparam int unsigned HALF      = OVERSAMPLE / 2;
  localparam int unsigned BCNT_W    = $clog2(DATA_BITS + 1);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENT_W     = DATA_BITS + 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } state_e;

  // Synchronizer and edge detect
  logic rx_meta_q;
  logic rx_s_q;
  logic rx_prev_q;

  // Baud tick generation
  logic [DIV_W-1:0]  div_q;
  logic              tick_c;
  logic              start_c;

  // Frame decoder
  state_e               state_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [BCNT_W-1:0]    bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q;
  logic                 par_err_q;
  logic                 frame_err_q;
  logic                 tick_last_c;
  logic                 sample_c;
  logic                 par_xor_c;
  logic                 push_q;
  logic [ENT_W-1:0]     push_entry_q;

  // Output FIFO
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             full_c;
  logic             pop_c;
  logic             wr_en_c;
  logic [ENT_W-1:0] head_c;

  // Two-stage synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign start_c = (state_q == ST_IDLE) && rx_prev_q && !rx_s_q;
  assign tick_c  = (div_q == DIV_W'(TICK_DIV - 1));

  // Oversample tick divider; restarted on every accepted start edge
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else if (start_c) begin
      div_q <= DIV_W'(SYNC_COMP);
    end else if (tick_c) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Start bit is checked half a bit in; every later bit one full bit apart
  assign tick_last_c = (state_q == ST_START) ? (tick_cnt_q == TICK_W'(HALF - 1))
                                             : (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));
  assign sample_c    = tick_c && tick_last_c;
  assign par_xor_c   = (^shift_q) ^ rx_s_q;

  // Frame decoder FSM: start validation, data/parity/stop sampling, break
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      push_q       <= 1'b0;
      push_entry_q <= '0;
    end else begin
      push_q <= 1'b0;

      if (state_q != ST_IDLE && state_q != ST_BREAK_WAIT && tick_c) begin
        tick_cnt_q <= tick_last_c ? '0 : tick_cnt_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            state_q     <= ST_START;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
          end
        end

        ST_START: begin
          if (sample_c) begin
            state_q <= rx_s_q ? ST_IDLE : ST_DATA;
          end
        end

        ST_DATA: begin
          if (sample_c) begin
            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BCNT_W'(DATA_BITS - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (sample_c) begin
            par_bit_q <= rx_s_q;
            par_err_q <= (PARITY == 1) ? !par_xor_c : par_xor_c;
            state_q   <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (sample_c) begin
            if (bit_cnt_q == '0 && shift_q == '0 && !par_bit_q && !rx_s_q) begin
              // Whole frame low through the first stop bit: report one break
              push_q       <= 1'b1;
              push_entry_q <= {1'b1, 1'b1, par_err_q, DATA_BITS'(0)};
              bit_cnt_q    <= '0;
              state_q      <= ST_BREAK_WAIT;
            end else if (bit_cnt_q == BCNT_W'(STOP_BITS - 1)) begin
              push_q       <= 1'b1;
              push_entry_q <= {1'b0, frame_err_q | !rx_s_q, par_err_q, shift_q};
              bit_cnt_q    <= '0;
              state_q      <= ST_IDLE;
            end else begin
              frame_err_q <= frame_err_q | !rx_s_q;
              bit_cnt_q   <= bit_cnt_q + 1'b1;
            end
          end
        end

        ST_BREAK_WAIT: begin
          if (rx_s_q) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign full_c  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop_c   = out_valid && out_ready;
  assign wr_en_c = push_q && (!full_c || pop_c);

  // FIFO storage; contents need no reset since the head is masked when empty
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= push_entry_q;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (wr_en_c && !pop_c) begin
        count_q <= count_q + 1'b1;
      end else if (!wr_en_c && pop_c) begin
        count_q <= count_q - 1'b1;
      end
      if (push_q && full_c && !pop_c) begin
        overflow_q <= 1'b1;
      end else if (clear_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign head_c         = mem_q[rd_ptr_q];
  assign out_valid      = (count_q != '0);
  assign out_data       = out_valid ? head_c[DATA_BITS-1:0] : '0;
  assign out_parity_err = out_valid && head_c[ENT_W-3];
  assign out_frame_err  = out_valid && head_c[ENT_W-2];
  assign out_break      = out_valid && head_c[ENT_W-1];
  assign fifo_count     = count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_uart_frame_monitor.sv
// Bench for uart_frame_monitor: three configurations (8N1 at 27 MHz,
// 8E1 with a 4-deep FIFO, 7O2), table-driven frames plus hand-written
// sequences for latency, break, overflow, glitch, reset and back-to-back.
`timescale 1ns/1ps
module tb_uart_frame_monitor;

  // 27 MHz / (115200*16) -> 14 clk per tick -> 224 clk per bit
  localparam int BIT_A  = 224;
  // 8 MHz / (115200*16) -> 4 clk per tick -> 64 clk per bit
  localparam int BIT_BC = 64;
  localparam int NV     = 10;

  typedef struct packed {
    logic       brk;
    logic       fe;
    logic       pe;
    logic [8:0] data;
  } ent_t;

  typedef struct {
    int         s;
    logic [8:0] data;
    logic       par_flip;
    logic       stop_low;
    ent_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rx;
  logic [2:0] rdy;
  logic [2:0] clr;

  logic       va, pa, fa, ba, oa;
  logic [7:0] da;
  logic [3:0] ca;
  logic       vb, pb, fb, bb, ob;
  logic [7:0] db;
  logic [2:0] cb;
  logic       vc, pc, fc, bc, oc;
  logic [6:0] dc;
  logic [3:0] cc;

  int   checks = 0;
  int   errors = 0;
  ent_t q0[$];
  ent_t q1[$];
  ent_t q2[$];
  vec_t tbl[NV];

  always #5 clk = ~clk;

  uart_frame_monitor u_a (
    .clk(clk), .reset(reset), .uart_rx(rx[0]),
    .out_valid(va), .out_ready(rdy[0]), .out_data(da),
    .out_parity_err(pa), .out_frame_err(fa), .out_break(ba),
    .fifo_count(ca), .overflow(oa), .clear_overflow(clr[0])
  );

  uart_frame_monitor #(
    .CLK_FREQ_MHZ(8), .PARITY(2), .FIFO_DEPTH(4)
  ) u_b (
    .clk(clk), .reset(reset), .uart_rx(rx[1]),
    .out_valid(vb), .out_ready(rdy[1]), .out_data(db),
    .out_parity_err(pb), .out_frame_err(fb), .out_break(bb),
    .fifo_count(cb), .overflow(ob), .clear_overflow(clr[1])
  );

  uart_frame_monitor #(
    .CLK_FREQ_MHZ(8), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)
  ) u_c (
    .clk(clk), .reset(reset), .uart_rx(rx[2]),
    .out_valid(vc), .out_ready(rdy[2]), .out_data(dc),
    .out_parity_err(pc), .out_frame_err(fc), .out_break(bc),
    .fifo_count(cc), .overflow(oc), .clear_overflow(clr[2])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic brk, input logic fe, input logic pe, input logic [8:0] d);
    ent_t e;
    e.brk  = brk;
    e.fe   = fe;
    e.pe   = pe;
    e.data = d;
    return e;
  endfunction

  function automatic int bit_clks(input int s);
    return (s == 0) ? BIT_A : BIT_BC;
  endfunction

  function automatic int valid_of(input int s);
    case (s)
      0:       return int'(va);
      1:       return int'(vb);
      default: return int'(vc);
    endcase
  endfunction

  function automatic ent_t head(input int s);
    case (s)
      0:       return mk(ba, fa, pa, {1'b0, da});
      1:       return mk(bb, fb, pb, {1'b0, db});
      default: return mk(bc, fc, pc, {2'b00, dc});
    endcase
  endfunction

  task automatic push_exp(input int s, input ent_t e);
    case (s)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic drive_bit(input int s, input logic b);
    rx[s] = b;
    repeat (bit_clks(s)) @(negedge clk);
  endtask

  // Full frame in the format of instance s, optional parity flip / low first stop
  task automatic send(input int s, input logic [8:0] d, input logic par_flip, input logic stop_low);
    int   nb, pm, ns;
    logic p;
    nb = (s == 2) ? 7 : 8;
    pm = (s == 0) ? 0 : ((s == 1) ? 2 : 1);
    ns = (s == 2) ? 2 : 1;
    drive_bit(s, 1'b0);
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      drive_bit(s, d[i]);
      p = p ^ d[i];
    end
    if (pm != 0) begin
      if (pm == 1) p = ~p;
      drive_bit(s, p ^ par_flip);
    end
    for (int i = 0; i < ns; i++) begin
      drive_bit(s, (i == 0 && stop_low) ? 1'b0 : 1'b1);
    end
    rx[s] = 1'b1;
  endtask

  // Wait (bounded) for a head entry, compare it with the scoreboard, pop it
  task automatic pop_check(input int s, input string name);
    ent_t e, h;
    int   w;
    w = 0;
    while (valid_of(s) == 0 && w < 4 * bit_clks(s)) begin
      @(negedge clk);
      w++;
    end
    if (valid_of(s) == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: out_valid never rose (got 0 expected 1)", name);
      return;
    end
    case (s)
      0:       begin if (q0.size() == 0) e = mk(1, 1, 1, 9'h1FF); else e = q0.pop_front(); end
      1:       begin if (q1.size() == 0) e = mk(1, 1, 1, 9'h1FF); else e = q1.pop_front(); end
      default: begin if (q2.size() == 0) e = mk(1, 1, 1, 9'h1FF); else e = q2.pop_front(); end
    endcase
    h = head(s);
    chk({name, ".data"}, int'(h.data), int'(e.data));
    chk({name, ".parity_err"}, int'(h.pe), int'(e.pe));
    chk({name, ".frame_err"}, int'(h.fe), int'(e.fe));
    chk({name, ".break"}, int'(h.brk), int'(e.brk));
    rdy[s] = 1'b1;
    @(negedge clk);
    rdy[s] = 1'b0;
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    tbl[0] = '{1, 9'h0A5, 1'b1, 1'b0, mk(0, 0, 1, 9'h0A5)};
    tbl[1] = '{1, 9'h0A5, 1'b0, 1'b0, mk(0, 0, 0, 9'h0A5)};
    tbl[2] = '{0, 9'h03C, 1'b0, 1'b1, mk(0, 1, 0, 9'h03C)};
    tbl[3] = '{0, 9'h07E, 1'b0, 1'b0, mk(0, 0, 0, 9'h07E)};
    tbl[4] = '{2, 9'h055, 1'b0, 1'b0, mk(0, 0, 0, 9'h055)};
    tbl[5] = '{2, 9'h02A, 1'b1, 1'b0, mk(0, 0, 1, 9'h02A)};
    tbl[6] = '{1, 9'h000, 1'b0, 1'b0, mk(0, 0, 0, 9'h000)};
    tbl[7] = '{2, 9'h040, 1'b0, 1'b1, mk(0, 1, 0, 9'h040)};
    tbl[8] = '{0, 9'h0FF, 1'b0, 1'b0, mk(0, 0, 0, 9'h0FF)};
    tbl[9] = '{1, 9'h081, 1'b1, 1'b1, mk(0, 1, 1, 9'h081)};

    reset = 1'b1;
    rx    = 3'b111;
    rdy   = 3'b000;
    clr   = 3'b000;
    repeat (5) @(negedge clk);
    chk("reset.valid", int'(va), 0);
    chk("reset.count", int'(ca), 0);
    chk("reset.data", int'(da), 0);
    chk("reset.overflow", int'(oa), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0x55: latency from start edge to out_valid
    lat = 0;
    push_exp(0, mk(0, 0, 0, 9'h055));
    fork
      send(0, 9'h055, 1'b0, 1'b0);
      begin
        while (va == 1'b0 && lat < 3000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    checks++;
    if (lat < 2100 || lat > 2130) begin
      errors++;
      $display("FAIL latency: got %0d clk expected 2100..2130", lat);
    end
    chk("first.count", int'(ca), 1);
    pop_check(0, "first");
    chk("first.count_after_pop", int'(ca), 0);

    // out_ready on an empty FIFO does nothing
    rdy[0] = 1'b1;
    repeat (3) @(negedge clk);
    rdy[0] = 1'b0;
    chk("empty_ready.count", int'(ca), 0);
    chk("empty_ready.valid", int'(va), 0);

    // Table-driven frames across all three configurations
    for (int i = 0; i < NV; i++) begin
      push_exp(tbl[i].s, tbl[i].exp);
      send(tbl[i].s, tbl[i].data, tbl[i].par_flip, tbl[i].stop_low);
      repeat (bit_clks(tbl[i].s)) @(negedge clk);
      pop_check(tbl[i].s, $sformatf("vec%0d", i));
    end

    // Break: line held low for three frame times gives exactly one entry
    push_exp(0, mk(1, 1, 0, 9'h000));
    rx[0] = 1'b0;
    repeat (30 * BIT_A) @(negedge clk);
    rx[0] = 1'b1;
    repeat (2 * BIT_A) @(negedge clk);
    chk("break.count", int'(ca), 1);
    pop_check(0, "break");
    chk("break.count_after_pop", int'(ca), 0);
    push_exp(0, mk(0, 0, 0, 9'h041));
    send(0, 9'h041, 1'b0, 1'b0);
    repeat (BIT_A) @(negedge clk);
    pop_check(0, "after_break");

    // Overflow on the 4-deep FIFO: fifth frame dropped
    for (int d = 1; d <= 5; d++) begin
      if (d <= 4) push_exp(1, mk(0, 0, 0, 9'(d)));
      send(1, 9'(d), 1'b0, 1'b0);
      repeat (BIT_BC) @(negedge clk);
    end
    chk("ovf.count", int'(cb), 4);
    chk("ovf.flag", int'(ob), 1);
    for (int i = 0; i < 4; i++) pop_check(1, $sformatf("ovf_pop%0d", i));
    chk("ovf.count_after_pops", int'(cb), 0);
    chk("ovf.sticky", int'(ob), 1);
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    chk("ovf.cleared", int'(ob), 0);

    // Glitch of 5 ticks is a false start
    rx[0] = 1'b0;
    repeat (5 * 14) @(negedge clk);
    rx[0] = 1'b1;
    repeat (2 * BIT_A) @(negedge clk);
    chk("glitch.valid", int'(va), 0);
    chk("glitch.count", int'(ca), 0);
    push_exp(0, mk(0, 0, 0, 9'h05A));
    send(0, 9'h05A, 1'b0, 1'b0);
    repeat (BIT_A) @(negedge clk);
    pop_check(0, "after_glitch");

    // Reset in the middle of 0x99 with one entry already queued
    push_exp(0, mk(0, 0, 0, 9'h012));
    send(0, 9'h012, 1'b0, 1'b0);
    repeat (BIT_A) @(negedge clk);
    chk("pre_reset.count", int'(ca), 1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    rx[0] = 1'b0;
    repeat (BIT_A / 2) @(negedge clk);
    reset = 1'b1;
    rx[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_reset.valid", int'(va), 0);
    chk("mid_reset.count", int'(ca), 0);
    chk("mid_reset.data", int'(da), 0);
    q0.delete();
    reset = 1'b0;
    repeat (12 * BIT_A) @(negedge clk);
    chk("post_reset.count", int'(ca), 0);
    push_exp(0, mk(0, 0, 0, 9'h099));
    send(0, 9'h099, 1'b0, 1'b0);
    repeat (BIT_A) @(negedge clk);
    pop_check(0, "after_reset");

    // Back-to-back 7O2 frames with no idle gap
    push_exp(2, mk(0, 0, 0, 9'h011));
    push_exp(2, mk(0, 0, 0, 9'h022));
    push_exp(2, mk(0, 0, 0, 9'h07F));
    push_exp(2, mk(0, 0, 0, 9'h000));
    send(2, 9'h011, 1'b0, 1'b0);
    send(2, 9'h022, 1'b0, 1'b0);
    send(2, 9'h07F, 1'b0, 1'b0);
    send(2, 9'h000, 1'b0, 1'b0);
    repeat (BIT_BC) @(negedge clk);
    chk("b2b.count", int'(cc), 4);
    for (int i = 0; i < 4; i++) pop_check(2, $sformatf("b2b%0d", i));
    chk("b2b.count_after_pops", int'(cc), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
